// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port RAM between the CPU and DMA ports.
// Each granted access runs IDLE -> ISSUE -> (WAIT) -> ACK and returns a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // Handshake: req is held until its one-cycle ack; a req still high in the
  // IDLE cycle right after the ack is treated as a brand-new transaction.
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  // WAIT lasts RD_LAT-1 cycles: the counter starts at RD_LAT-2 and exits on zero.
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_hold;
  logic [DATA_W-1:0] r_dma_hold;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_grant;
  logic              w_winner;
  logic              w_in_ack;

  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_winner = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          w_grant  = 1'b1;
          w_winner = (cpu_req && dma_req) ? ~r_last_owner : dma_req;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: w_next = (r_we || RD_LAT == 1) ? S_ACK : S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_cpu_hold   <= '0;
      r_dma_hold   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        r_we         <= w_winner ? dma_we    : cpu_we;
        r_addr       <= w_winner ? dma_addr  : cpu_addr;
        r_wdata      <= w_winner ? dma_wdata : cpu_wdata;
      end
      if (r_state == S_ISSUE) r_cnt <= WAIT_INIT;
      else if (r_state == S_WAIT) r_cnt <= r_cnt - CNT_W'(1);
      // Capture read data so each port's rdata stays stable after its ack.
      if (r_state == S_ACK && !r_we) begin
        if (r_owner) r_dma_hold <= ram_rdata;
        else         r_cpu_hold <= ram_rdata;
      end
    end
  end

  assign w_in_ack  = (r_state == S_ACK);
  assign cpu_ack   = w_in_ack && !r_owner;
  assign dma_ack   = w_in_ack &&  r_owner;
  assign cpu_rdata = (cpu_ack && !r_we) ? ram_rdata : r_cpu_hold;
  assign dma_rdata = (dma_ack && !r_we) ? ram_rdata : r_dma_hold;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign ram_we    = (r_state == S_ISSUE) && r_we;
  assign busy      = (r_state != S_IDLE);
  assign owner     = r_owner;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT = 1 and 3), each with a RAM model,
// checked every cycle against a transaction-level reference model and scoreboard.
module tb_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  typedef struct {
    int            inst;
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            grant_c;
    int            ack_c;
  } txn_t;

  logic          clk;
  logic          rst       [2];
  logic          cpu_req   [2];
  logic          cpu_we    [2];
  logic [AW-1:0] cpu_addr  [2];
  logic [DW-1:0] cpu_wdata [2];
  logic          cpu_ack   [2];
  logic [DW-1:0] cpu_rdata [2];
  logic          dma_req   [2];
  logic          dma_we    [2];
  logic [AW-1:0] dma_addr  [2];
  logic [DW-1:0] dma_wdata [2];
  logic          dma_ack   [2];
  logic [DW-1:0] dma_rdata [2];
  logic [AW-1:0] ram_addr  [2];
  logic [DW-1:0] ram_wdata [2];
  logic          ram_we    [2];
  logic [DW-1:0] ram_rdata [2];
  logic          busy      [2];
  logic          owner     [2];
  logic [1:0]    dbg_state [2];

  // Reference state
  txn_t          exp_q[$];
  logic [DW-1:0] ref_mem [2][512];
  logic [DW-1:0] hold    [2][2];
  int            free_c  [2];
  bit            last_own[2];
  bit            armed   [2];
  bit            was_rst [2];
  int            cyc = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  bit            end_req = 0;
  bit            done = 0;
  bit            ack_prev [2][2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem  [512] = '{default: '0};
    logic [DW-1:0] pipe [LAT];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst[g]),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_ack(dma_ack[g]), .dma_rdata(dma_rdata[g]),
      .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_we(ram_we[g]),
      .ram_rdata(ram_rdata[g]), .busy(busy[g]), .owner(owner[g]),
      .dbg_state(dbg_state[g])
    );

    // Synchronous RAM: data for the address presented in cycle c appears in cycle c+LAT.
    always @(posedge clk) begin
      if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
      pipe[0] <= mem[ram_addr[g]];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_rdata[g] = pipe[LAT-1];
  end

  function automatic void chk(input int i, input string nm, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s cycle %0d: got %h expected %h", i, nm, cyc, act, exp);
    end
  endfunction

  function automatic int find_inst(input int i);
    for (int j = 0; j < exp_q.size(); j++)
      if (exp_q[j].inst == i) return j;
    return -1;
  endfunction

  task automatic monitor(input int i);
    txn_t t;
    int   j;
    bit   has, e_cack, e_dack, issue;
    j   = find_inst(i);
    has = (j >= 0);
    if (has) t = exp_q[j];
    e_cack = has && t.ack_c == cyc && !t.port;
    e_dack = has && t.ack_c == cyc &&  t.port;
    issue  = has && cyc == t.grant_c + 1;
    chk(i, "cpu_ack", DW'(cpu_ack[i]), DW'(e_cack));
    chk(i, "dma_ack", DW'(dma_ack[i]), DW'(e_dack));
    chk(i, "busy",    DW'(busy[i]),    DW'(has && cyc > t.grant_c));
    chk(i, "ram_we",  DW'(ram_we[i]),  DW'(issue && t.we));
    if (was_rst[i]) begin
      chk(i, "rst_owner",     DW'(owner[i]),    '0);
      chk(i, "rst_ram_addr",  DW'(ram_addr[i]), '0);
      chk(i, "rst_ram_wdata", ram_wdata[i],     '0);
      was_rst[i] = 0;
    end
    if (issue) begin
      chk(i, "ram_addr", DW'(ram_addr[i]), DW'(t.addr));
      if (t.we) chk(i, "ram_wdata", ram_wdata[i], t.wdata);
    end
    if (e_cack || e_dack) begin
      chk(i, "owner", DW'(owner[i]), DW'(t.port));
      if (!t.we) hold[i][t.port] = t.rdata;
      exp_q.delete(j);
    end
    chk(i, "cpu_rdata", cpu_rdata[i], hold[i][0]);
    chk(i, "dma_rdata", dma_rdata[i], hold[i][1]);
  endtask

  // Inputs seen here are the ones the DUT samples at the coming edge.
  task automatic model(input int i);
    txn_t t;
    int   lat;
    lat = (i == 0) ? 1 : 3;
    if (rst[i]) begin
      for (int j = exp_q.size() - 1; j >= 0; j--)
        if (exp_q[j].inst == i) exp_q.delete(j);
      free_c[i]   = cyc + 1;
      last_own[i] = 1'b1;
      hold[i][0]  = '0;
      hold[i][1]  = '0;
      armed[i]    = 1'b1;
      was_rst[i]  = 1'b1;
    end else if (armed[i] && cyc >= free_c[i] && (cpu_req[i] || dma_req[i])) begin
      t.inst    = i;
      t.port    = (cpu_req[i] && dma_req[i]) ? !last_own[i] : dma_req[i];
      t.we      = t.port ? dma_we[i]    : cpu_we[i];
      t.addr    = t.port ? dma_addr[i]  : cpu_addr[i];
      t.wdata   = t.port ? dma_wdata[i] : cpu_wdata[i];
      t.grant_c = cyc;
      t.ack_c   = cyc + (t.we ? 2 : 1 + lat);
      if (t.we) begin
        ref_mem[i][t.addr] = t.wdata;
        t.rdata = '0;
      end else begin
        t.rdata = ref_mem[i][t.addr];
      end
      free_c[i]   = t.ack_c + 1;
      last_own[i] = t.port;
      exp_q.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    if (cyc == 0)
      for (int i = 0; i < 2; i++)
        for (int a = 0; a < 512; a++) ref_mem[i][a] = '0;
    for (int i = 0; i < 2; i++) begin
      if (armed[i]) monitor(i);
      model(i);
    end
    if (end_req && !done) begin
      for (int i = 0; i < 2; i++) chk(i, "drained", DW'(find_inst(i) + 1), '0);
      done = 1'b1;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input bit p, input bit req, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!p) begin
      cpu_req[i] = req; cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d;
    end else begin
      dma_req[i] = req; dma_we[i] = we; dma_addr[i] = a; dma_wdata[i] = d;
    end
  endtask

  function automatic bit ack_of(input int i, input bit p);
    return p ? dma_ack[i] : cpu_ack[i];
  endfunction

  function automatic bit req_of(input int i, input bit p);
    return p ? dma_req[i] : cpu_req[i];
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
  endfunction

  task automatic wait_ack(input int i, input bit p);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      next_cyc();
      n++;
      seen = ack_of(i, p);
    end
    if (seen) next_cyc();
  endtask

  task automatic txn(input int i, input bit p, input bit we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    set_port(i, p, 1'b1, we, a, d);
    wait_ack(i, p);
    set_port(i, p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic pulse_reset(input int i);
    set_port(i, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(i, 1'b1, 1'b0, 1'b0, '0, '0);
    rst[i] = 1'b1;
    idle(2);
    rst[i] = 1'b0;
  endtask

  // mode 0: random traffic, 1: both ports always request writes, 2: finish and go quiet
  task automatic step(input int i, input int mode);
    bit p;
    for (int pi = 0; pi < 2; pi++) begin
      p = pi[0];
      if (ack_prev[i][pi] || !req_of(i, p)) begin
        if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1))
          set_port(i, p, 1'b1, (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                   rand_addr(), $urandom);
        else
          set_port(i, p, 1'b0, 1'b0, '0, '0);
      end else if (mode == 0 && $urandom_range(0, 3) == 0) begin
        set_port(i, p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      end
      ack_prev[i][pi] = ack_of(i, p);
    end
  endtask

  task automatic clr_prev(input int i);
    ack_prev[i][0] = 1'b0;
    ack_prev[i][1] = 1'b0;
  endtask

  task automatic directed(input int i);
    logic [DW-1:0] va, vb;
    va = $urandom;
    vb = ~va;
    pulse_reset(i);
    txn(i, 1'b0, 1'b1, 9'h012, 32'hDEADBEEF);
    txn(i, 1'b0, 1'b0, 9'h012, '0);
    idle(10);
    // Contention straight after reset: CPU must win the first tie.
    pulse_reset(i);
    clr_prev(i);
    repeat (12) begin step(i, 1); next_cyc(); end
    repeat (12) begin step(i, 2); next_cyc(); end
    // Address change after the grant must be ignored.
    txn(i, 1'b1, 1'b1, 9'h020, va);
    txn(i, 1'b1, 1'b1, 9'h030, vb);
    set_port(i, 1'b1, 1'b1, 1'b0, 9'h020, '0);
    next_cyc();
    set_port(i, 1'b1, 1'b1, 1'b0, 9'h030, '0);
    wait_ack(i, 1'b1);
    set_port(i, 1'b1, 1'b0, 1'b0, '0, '0);
    // Reset while a CPU read is in flight, then a fresh tie.
    idle(3);
    set_port(i, 1'b0, 1'b1, 1'b0, 9'h012, '0);
    idle(2);
    rst[i] = 1'b1;
    next_cyc();
    rst[i] = 1'b0;
    set_port(i, 1'b0, 1'b0, 1'b0, '0, '0);
    clr_prev(i);
    step(i, 1);
    repeat (12) begin next_cyc(); step(i, 2); end
    // Top-of-memory address, written by DMA and read back by CPU.
    txn(i, 1'b1, 1'b0, 9'h020, '0);
    txn(i, 1'b1, 1'b1, 9'h1FF, 32'h5A5A0001);
    txn(i, 1'b0, 1'b0, 9'h1FF, '0);
    idle(4);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      set_port(i, 1'b0, 1'b0, 1'b0, '0, '0);
      set_port(i, 1'b1, 1'b0, 1'b0, '0, '0);
      clr_prev(i);
    end
    idle(3);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    idle(2);
    for (int i = 0; i < 2; i++) directed(i);
    clr_prev(0);
    clr_prev(1);
    repeat (600) begin
      step(0, 0);
      step(1, 0);
      next_cyc();
    end
    repeat (20) begin
      step(0, 2);
      step(1, 2);
      next_cyc();
    end
    end_req = 1'b1;
    for (int n = 0; n < 5 && !done; n++) @(posedge clk);
    if (!done) $display("FAIL drain_timeout: got done=0 expected done=1");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk,
             done ? n_fail : n_fail + 1);
    $finish;
  end

endmodule
